// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the L1 data cache slice.
// Provides the word type, cache geometry, the address breakdown used to
// index the data cache, the per-line storage record and the cache FSM
// state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int SETS  = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 26;

  // Word address split: tag | index | byte offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } dcachef_t;

  // MSI line state: I = !valid, S = valid & !dirty, M = valid & dirty.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } dline_t;

  // Cache controller states, kept as plain constants so older code that
  // compares raw state bits keeps working.
  typedef logic [2:0] dcache_state_t;
  localparam dcache_state_t IDLE    = 3'd0;
  localparam dcache_state_t WB      = 3'd1;
  localparam dcache_state_t FETCH   = 3'd2;
  localparam dcache_state_t FLUSH   = 3'd3;
  localparam dcache_state_t FLUSHED = 3'd4;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   rd_idx/rd_line   combinational read port (datapath or flush index)
//   sn_idx/sn_line   combinational read port (snoop index)
//   wr_en/wr_idx/wr_line  single write port, arbitrated by the parent
module dcache_array
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output dline_t           rd_line,
  input  logic [IDX_W-1:0] sn_idx,
  output dline_t           sn_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  dline_t           wr_line
);

  dline_t lines_q [SETS];
  dline_t lines_d [SETS];

  // NOTE: every combinational output gets a default at the top of the block
  // so no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lines_d = lines_q;
    if (wr_en) lines_d[wr_idx] = wr_line;
  end

  // NOTE: the array is reset in full because an asynchronous reset must leave
  // every line invalid and clean; a storage-only RAM without reset would not.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) lines_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment for state so every flop samples
      // pre-edge values regardless of block ordering.
      lines_q <= lines_d;
    end
  end

  assign rd_line = lines_q[rd_idx];
  assign sn_line = lines_q[sn_idx];

endmodule

// File: rtl/coherent_dcache.sv
// Per-CPU L1 data cache: direct-mapped, one-word lines, write-back,
// write-allocate, MSI coherence through a dual-CPU memory controller.
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   halt                           start write-back flush of all lines
//   dmemREN/dmemWEN/dmemaddr/dmemstore  datapath request
//   dhit/dmemload                  datapath completion and read data
//   flushed                        flush done, sticky until reset
//   dwait/dload                    controller handshake and fill data
//   dREN/dWEN/daddr/dstore         bus request toward the controller
//   cctrans/ccwrite                coherence transaction (BusRd/BusRdX)
//   ccwait/ccinv/ccsnoopaddr       snoop request from the controller
module coherent_dcache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  dcachef_t         req_f, snp_f;
  dline_t           rd_line, sn_line, wr_line;
  logic             wr_en;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  dcache_state_t    state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic             hit, victim_m, snoop_hit;
  logic             unused_bytoff;

  assign req_f = dcachef_t'(dmemaddr);
  assign snp_f = dcachef_t'(ccsnoopaddr);
  assign unused_bytoff = ^{req_f.bytoff, snp_f.bytoff};

  // The flush walk borrows the datapath read port.
  assign rd_idx = (state_q == FLUSH) ? flush_idx_q : req_f.idx;

  dcache_array u_array (
    .CLK     (CLK),
    .nRST    (nRST),
    .rd_idx  (rd_idx),
    .rd_line (rd_line),
    .sn_idx  (snp_f.idx),
    .sn_line (sn_line),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_line (wr_line)
  );

  assign hit       = rd_line.valid && (rd_line.tag == req_f.tag);
  assign victim_m  = rd_line.valid && rd_line.dirty;
  assign snoop_hit = sn_line.valid && (sn_line.tag == snp_f.tag);
  assign flushed   = (state_q == FLUSHED);

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    dhit        = 1'b0;
    dmemload    = '0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    cctrans     = 1'b0;
    ccwrite     = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = rd_idx;
    wr_line     = rd_line;

    if (ccwait) begin
      // Snoop owns the array write port and the bus; the FSM freezes.
      wr_idx  = snp_f.idx;
      wr_line = sn_line;
      if (snoop_hit && sn_line.dirty) begin
        dWEN   = 1'b1;
        daddr  = ccsnoopaddr;
        dstore = sn_line.data;
        if (!dwait) begin
          wr_en         = 1'b1;
          wr_line.dirty = 1'b0;
          wr_line.valid = !ccinv;
        end
      end else if (snoop_hit && ccinv) begin
        wr_en         = 1'b1;
        wr_line.valid = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (halt) begin
            state_d     = FLUSH;
            flush_idx_d = '0;
          end else if (dmemWEN) begin
            if (hit && rd_line.dirty) begin
              dhit         = 1'b1;
              wr_en        = 1'b1;
              wr_line.data = dmemstore;
            end else if (hit) begin
              state_d = FETCH;             // S -> M upgrade via BusRdX
            end else begin
              state_d = victim_m ? WB : FETCH;
            end
          end else if (dmemREN) begin
            if (hit) begin
              dhit     = 1'b1;
              dmemload = rd_line.data;
            end else begin
              state_d = victim_m ? WB : FETCH;
            end
          end
        end
        WB: begin
          // A snoop may have cleaned or dropped the victim meanwhile.
          if (victim_m) begin
            dWEN   = 1'b1;
            daddr  = {rd_line.tag, req_f.idx, 2'b00};
            dstore = rd_line.data;
            if (!dwait) begin
              wr_en         = 1'b1;
              wr_line.dirty = 1'b0;
              state_d       = FETCH;
            end
          end else begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          dREN    = 1'b1;
          cctrans = 1'b1;
          ccwrite = dmemWEN;
          daddr   = dmemaddr;
          if (!dwait) begin
            wr_en         = 1'b1;
            wr_line.valid = 1'b1;
            wr_line.dirty = dmemWEN;
            wr_line.tag   = req_f.tag;
            wr_line.data  = dmemWEN ? dmemstore : dload;
            state_d       = IDLE;
          end
        end
        FLUSH: begin
          if (victim_m) begin
            dWEN   = 1'b1;
            daddr  = {rd_line.tag, flush_idx_q, 2'b00};
            dstore = rd_line.data;
          end
          // Clean lines retire in one cycle; dirty ones wait for the bus.
          if (!victim_m || !dwait) begin
            wr_en       = 1'b1;
            wr_line     = '0;
            flush_idx_d = flush_idx_q + 1'b1;
            if (flush_idx_q == IDX_W'(SETS - 1)) state_d = FLUSHED;
          end
        end
        FLUSHED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

endmodule

// File: doc/coherent_dcache.md
Name: coherent_dcache

Overview:
- Per-CPU L1 data cache. Sits between the datapath memory port and one data/coherence port of the dual-CPU memory controller.
- Direct-mapped, one-word lines, write-back and write-allocate, with MSI coherence.
- Issues BusRd/BusRdX via cctrans/ccwrite, answers snoops from the controller, and flushes dirty lines on halt.

Parameters:
SETS, 16, number of lines; index = dmemaddr[5:2] for 16 sets; tag = addr[31:6]

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
halt  in  1  datapath halted; start flush
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
dmemaddr  in  32  word address (bits 1:0 ignored)
dmemstore  in  32  store data
dhit  out  1  request complete this cycle
dmemload  out  32  read data
flushed  out  1  flush complete, sticky until reset
dwait  in  1  controller wait (low = word accepted/returned)
dload  in  32  fill data from controller
dREN  out  1  bus read
dWEN  out  1  bus write (victim, flush or snoop writeback)
daddr  out  32  bus address
dstore  out  32  bus write data
cctrans  out  1  coherence transaction with dREN
ccwrite  out  1  1 = BusRdX, 0 = BusRd
ccwait  in  1  snoop in progress on this cache
ccinv  in  1  invalidate snooped line
ccsnoopaddr  in  32  snoop address

Behaviour:
- Reset: all lines invalid/clean, FSM = IDLE, and every output 0 (flushed = 0).
- Line state encoding: I = !valid; S = valid & !dirty; M = valid & dirty.
- FSM states: IDLE, WB, FETCH, FLUSH, FLUSHED.
- IDLE, read hit (any valid line): dhit = 1 and dmemload = data, both combinational, same cycle.
- IDLE, write hit on M: dhit = 1 same cycle; data is written at the clock edge.
- IDLE, write hit on S: treated as a miss with ccwrite = 1; go to FETCH (no victim writeback).
- IDLE, miss:
  - Victim in M -> WB.
  - Otherwise -> FETCH.
- WB:
  - Drives dWEN = 1, daddr = {victim tag, index, 2'b00}, dstore = victim data, cctrans = 0.
  - On dwait = 0, the line becomes clean; next state FETCH.
  - If the victim is found clean on entry (e.g. after a snoop writeback), go to FETCH without a bus write.
- FETCH:
  - Drives dREN = 1, cctrans = 1, ccwrite = dmemWEN, daddr = dmemaddr.
  - On dwait = 0, fill the line with the tag.
  - Read miss: data = dload, state S.
  - Write miss: data = dmemstore, state M.
  - Next state IDLE. The request hits on the following cycle, so miss latency is 2 cycles plus bus wait.
- Snoop overlay:
  - Applies in every state while ccwait = 1 and takes priority over the FSM.
  - dREN, cctrans and ccwrite are forced to 0, dhit to 0, and the FSM holds its state.
  - The snoop lookup on ccsnoopaddr is combinational.
  - If the snoop hits M: dWEN = 1, daddr = ccsnoopaddr, dstore = line data, driven in the first ccwait cycle (Mealy; the controller samples dWEN that cycle). On dwait = 0 the line goes to S, or to I if ccinv = 1; then dWEN drops.
  - If the snoop hits S and ccinv = 1: the line goes to I at the clock edge.
  - If the snoop misses or hits S with ccinv = 0: no action, dWEN = 0.
- Snoop during a pending miss to the same line: invalidate/downgrade applies first. The FSM re-evaluates when ccwait falls: WB skips if clean, and FETCH refills regardless.
- halt = 1 in IDLE -> FLUSH, with flush index counter = 0.
- FLUSH:
  - For each index: if M, drive dWEN with {tag, idx, 00} and line data; on dwait = 0, invalidate the line and increment the counter.
  - Non-dirty lines are invalidated and the counter increments in one cycle.
  - After index SETS-1 -> FLUSHED.
- FLUSHED: flushed = 1; datapath requests are ignored (dhit = 0); snoops are still answered (all lines invalid, so always a miss).
- Simultaneous dmemREN and dmemWEN is illegal; when both are asserted, the write takes precedence.
- Async reset mid-transaction: the bus request drops immediately and all lines become invalid.

Decomposition:
- Extend cpu_types_pkg with:
  - dcachef_t packed struct {tag[25:0], idx[3:0], bytoff[1:0]}.
  - dline_t {valid, dirty, tag, word_t data}.
  - dcache_state_t enum.
- Sub-module dcache_array: SETS-entry register file with two combinational read ports (datapath index, snoop index) and one write port. The write port is arbitrated in the parent: snoop update beats fill beats datapath write.

Test Plan:
- Read miss 0x100 with dload = 0xDEADBEEF, dwait low after 3 cycles -> dREN, cctrans = 1, ccwrite = 0, daddr = 0x100; next cycle dhit = 1, dmemload = 0xDEADBEEF, line S.
- Write 0x55 to S line 0x100 -> BusRdX (cctrans = 1, ccwrite = 1), then line M with data 0x55 and no dWEN.
- Line 0x100 in M with data 0x55, then read miss 0x140 (same index) -> first dWEN daddr = 0x100 dstore = 0x55, then dREN daddr = 0x140.
- ccwait = 1, ccsnoopaddr = 0x100, line M, ccinv = 1 -> dWEN = 1 in the same cycle, dstore = 0x55; after dwait = 0 the line is I and a read of 0x100 misses.
- Snoop with ccinv = 1 to S line while dmemREN pending on another address -> dREN suppressed during ccwait, line I, miss then completes.
- halt with lines 3 and 9 dirty -> exactly two dWEN writebacks, in index order; flushed = 1 after index 15 and stays high.
